// File: rtl/mem_arbiter.sv
// Two-master Wishbone arbiter onto one shared memory port (m0 = icache, m1 = dcache).
// Ties alternate via last_grant; a per-transfer stall counter turns a silent memory into an err.
module mem_arbiter #(
   parameter int unsigned WORD_SIZE      = 256,
   parameter int unsigned ADDR_WIDTH     = 32,
   parameter int unsigned TIMEOUT_CYCLES = 1024
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  m0_cyc_i,
   input  logic                  m0_stb_i,
   input  logic                  m0_we_i,
   input  logic [ADDR_WIDTH-1:0] m0_addr_i,
   input  logic [WORD_SIZE-1:0]  m0_mosi_i,
   output logic                  m0_ack_o,
   output logic                  m0_err_o,
   output logic [WORD_SIZE-1:0]  m0_miso_o,
   input  logic                  m1_cyc_i,
   input  logic                  m1_stb_i,
   input  logic                  m1_we_i,
   input  logic [ADDR_WIDTH-1:0] m1_addr_i,
   input  logic [WORD_SIZE-1:0]  m1_mosi_i,
   output logic                  m1_ack_o,
   output logic                  m1_err_o,
   output logic [WORD_SIZE-1:0]  m1_miso_o,
   output logic                  mem_cyc_o,
   output logic                  mem_stb_o,
   output logic                  mem_we_o,
   output logic [ADDR_WIDTH-1:0] mem_addr_o,
   output logic [WORD_SIZE-1:0]  mem_mosi_o,
   input  logic                  mem_ack_i,
   input  logic [WORD_SIZE-1:0]  mem_miso_i
);

   // A zero timeout still needs a legal 1-bit counter; it is simply never compared.
   localparam int unsigned     CNT_W      = (TIMEOUT_CYCLES == 0) ? 1 : $clog2(TIMEOUT_CYCLES + 1);
   localparam bit              TIMEOUT_EN = (TIMEOUT_CYCLES != 0);
   localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'((TIMEOUT_CYCLES == 0) ? 0 : TIMEOUT_CYCLES - 1);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      GRANT0 = 2'd1,
      GRANT1 = 2'd2
   } state_e;

   state_e           state_q, state_d;
   logic             last_grant_q, last_grant_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;

   logic                  granted;
   logic                  g_cyc, g_stb, g_we;
   logic [ADDR_WIDTH-1:0] g_addr;
   logic [WORD_SIZE-1:0]  g_mosi;
   logic                  stall_c, timeout_c, ack_c;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q      <= IDLE;
         last_grant_q <= 1'b1;
         cnt_q        <= '0;
      end else begin
         state_q      <= state_d;
         last_grant_q <= last_grant_d;
         cnt_q        <= cnt_d;
      end
   end

   always_comb begin
      state_d      = state_q;
      last_grant_d = last_grant_q;
      cnt_d        = '0;
      granted      = 1'b0;
      g_cyc        = 1'b0;
      g_stb        = 1'b0;
      g_we         = 1'b0;
      g_addr       = '0;
      g_mosi       = '0;
      stall_c      = 1'b0;
      timeout_c    = 1'b0;
      ack_c        = 1'b0;
      mem_cyc_o    = 1'b0;
      mem_stb_o    = 1'b0;
      mem_we_o     = 1'b0;
      mem_addr_o   = '0;
      mem_mosi_o   = '0;
      m0_ack_o     = 1'b0;
      m0_err_o     = 1'b0;
      m0_miso_o    = '0;
      m1_ack_o     = 1'b0;
      m1_err_o     = 1'b0;
      m1_miso_o    = '0;

      case (state_q)
         IDLE: begin
            // last_grant names the previous winner, so a tie goes to the other master
            if (m0_cyc_i && m1_cyc_i) begin
               state_d      = last_grant_q ? GRANT0 : GRANT1;
               last_grant_d = ~last_grant_q;
            end else if (m0_cyc_i) begin
               state_d      = GRANT0;
               last_grant_d = 1'b0;
            end else if (m1_cyc_i) begin
               state_d      = GRANT1;
               last_grant_d = 1'b1;
            end
         end
         GRANT0, GRANT1: begin
            granted   = (state_q == GRANT1);
            g_cyc     = granted ? m1_cyc_i  : m0_cyc_i;
            g_stb     = granted ? m1_stb_i  : m0_stb_i;
            g_we      = granted ? m1_we_i   : m0_we_i;
            g_addr    = granted ? m1_addr_i : m0_addr_i;
            g_mosi    = granted ? m1_mosi_i : m0_mosi_i;
            ack_c     = g_cyc && g_stb && mem_ack_i;
            stall_c   = g_cyc && g_stb && !mem_ack_i;
            timeout_c = TIMEOUT_EN && stall_c && (cnt_q == CNT_LAST);
            cnt_d     = (stall_c && !timeout_c) ? cnt_q + CNT_W'(1) : '0;

            mem_cyc_o  = g_cyc && !timeout_c;
            mem_stb_o  = g_stb && !timeout_c;
            mem_we_o   = g_we;
            mem_addr_o = g_addr;
            mem_mosi_o = g_mosi;

            if (granted) begin
               m1_ack_o  = ack_c;
               m1_err_o  = timeout_c;
               m1_miso_o = mem_miso_i;
            end else begin
               m0_ack_o  = ack_c;
               m0_err_o  = timeout_c;
               m0_miso_o = mem_miso_i;
            end

            if (!g_cyc || timeout_c) state_d = IDLE;
            if (timeout_c) last_grant_d = granted;
         end
         default: state_d = IDLE;
      endcase
   end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: arbitration, pass-through, starvation, timeout and reset abort.
// Inputs change just after the falling edge; outputs are sampled 1 time unit later.
module tb_mem_arbiter;

   localparam int unsigned WS = 256;
   localparam int unsigned AW = 32;

   logic          clk = 1'b0;
   logic          rst;
   logic          m0_cyc_i, m0_stb_i, m0_we_i;
   logic [AW-1:0] m0_addr_i;
   logic [WS-1:0] m0_mosi_i;
   logic          m0_ack_o, m0_err_o;
   logic [WS-1:0] m0_miso_o;
   logic          m1_cyc_i, m1_stb_i, m1_we_i;
   logic [AW-1:0] m1_addr_i;
   logic [WS-1:0] m1_mosi_i;
   logic          m1_ack_o, m1_err_o;
   logic [WS-1:0] m1_miso_o;
   logic          mem_cyc_o, mem_stb_o, mem_we_o;
   logic [AW-1:0] mem_addr_o;
   logic [WS-1:0] mem_mosi_o;
   logic          mem_ack_i;
   logic [WS-1:0] mem_miso_i;

   int unsigned n_checks = 0;
   int unsigned n_fail   = 0;

   localparam logic [AW-1:0] A0 = 32'h0000_0040;
   localparam logic [AW-1:0] A1 = 32'h0000_1000;
   localparam logic [AW-1:0] A2 = 32'h0000_2000;
   localparam logic [WS-1:0] PAT_A5 = {32{8'hA5}};
   localparam logic [WS-1:0] PAT_RD = {16{16'h5A3C}};

   mem_arbiter #(
      .WORD_SIZE      (WS),
      .ADDR_WIDTH     (AW),
      .TIMEOUT_CYCLES (8)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .m0_cyc_i   (m0_cyc_i),
      .m0_stb_i   (m0_stb_i),
      .m0_we_i    (m0_we_i),
      .m0_addr_i  (m0_addr_i),
      .m0_mosi_i  (m0_mosi_i),
      .m0_ack_o   (m0_ack_o),
      .m0_err_o   (m0_err_o),
      .m0_miso_o  (m0_miso_o),
      .m1_cyc_i   (m1_cyc_i),
      .m1_stb_i   (m1_stb_i),
      .m1_we_i    (m1_we_i),
      .m1_addr_i  (m1_addr_i),
      .m1_mosi_i  (m1_mosi_i),
      .m1_ack_o   (m1_ack_o),
      .m1_err_o   (m1_err_o),
      .m1_miso_o  (m1_miso_o),
      .mem_cyc_o  (mem_cyc_o),
      .mem_stb_o  (mem_stb_o),
      .mem_we_o   (mem_we_o),
      .mem_addr_o (mem_addr_o),
      .mem_mosi_o (mem_mosi_o),
      .mem_ack_i  (mem_ack_i),
      .mem_miso_i (mem_miso_i)
   );

   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input logic [WS-1:0] got, input logic [WS-1:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      rst = 1'b1;
      m0_cyc_i = 1'b0; m0_stb_i = 1'b0; m0_we_i = 1'b0; m0_addr_i = '0; m0_mosi_i = '0;
      m1_cyc_i = 1'b0; m1_stb_i = 1'b0; m1_we_i = 1'b0; m1_addr_i = '0; m1_mosi_i = '0;
      mem_ack_i = 1'b0; mem_miso_i = '0;

      // reset state
      @(negedge clk); #1;
      check_eq("rst_cyc",  WS'(mem_cyc_o), '0);
      check_eq("rst_addr", WS'(mem_addr_o), '0);
      check_eq("rst_ack0", WS'(m0_ack_o), '0);
      check_eq("rst_err1", WS'(m1_err_o), '0);

      // simultaneous request at release: m0 wins, m1 follows after one IDLE cycle
      @(negedge clk);
      rst = 1'b0;
      m0_cyc_i = 1'b1; m0_stb_i = 1'b1; m0_addr_i = A0;
      m1_cyc_i = 1'b1; m1_stb_i = 1'b1; m1_we_i = 1'b1; m1_addr_i = A1; m1_mosi_i = PAT_A5;
      #1 check_eq("rel_idle_cyc", WS'(mem_cyc_o), '0);
      @(negedge clk); #1;
      check_eq("g0_cyc",  WS'(mem_cyc_o), WS'(1));
      check_eq("g0_addr", WS'(mem_addr_o), WS'(A0));
      check_eq("g0_we",   WS'(mem_we_o), '0);
      @(negedge clk);
      m0_cyc_i = 1'b0; m0_stb_i = 1'b0;
      #1 check_eq("g0_drop_cyc", WS'(mem_cyc_o), '0);
      @(negedge clk); #1;
      check_eq("gap_idle_cyc", WS'(mem_cyc_o), '0);

      // m1 write, ack on the 4th granted cycle
      @(negedge clk); #1;
      check_eq("g1_cyc",  WS'(mem_cyc_o), WS'(1));
      check_eq("g1_addr", WS'(mem_addr_o), WS'(A1));
      check_eq("g1_mosi", mem_mosi_o, PAT_A5);
      check_eq("g1_we_w0", WS'(mem_we_o), WS'(1));
      check_eq("g1_noack0", WS'(m1_ack_o), '0);
      for (int i = 1; i < 3; i++) begin
         @(negedge clk); #1;
         check_eq("g1_we_w", WS'(mem_we_o), WS'(1));
         check_eq("g1_noack", WS'(m1_ack_o), '0);
      end
      @(negedge clk);
      mem_ack_i = 1'b1; mem_miso_i = PAT_RD;
      #1;
      check_eq("g1_ack",    WS'(m1_ack_o), WS'(1));
      check_eq("g1_m0_ack", WS'(m0_ack_o), '0);
      check_eq("g1_miso",   m1_miso_o, PAT_RD);
      check_eq("g1_m0_miso", m0_miso_o, '0);
      check_eq("g1_we_ack", WS'(mem_we_o), WS'(1));
      @(negedge clk);
      mem_ack_i = 1'b0; m1_stb_i = 1'b0;
      #1 check_eq("g1_ack_pulse", WS'(m1_ack_o), '0);
      @(negedge clk);
      m1_cyc_i = 1'b0; m1_we_i = 1'b0;
      #1 check_eq("g1_drop_cyc", WS'(mem_cyc_o), '0);

      // spurious ack while idle
      @(negedge clk);
      mem_ack_i = 1'b1;
      #1;
      check_eq("spur_ack0", WS'(m0_ack_o), '0);
      check_eq("spur_ack1", WS'(m1_ack_o), '0);
      @(negedge clk);
      mem_ack_i = 1'b0;
      #1 check_eq("spur_idle", WS'(mem_cyc_o), '0);

      // m0 holds cyc for 4 stb/ack pairs; m1 starves
      @(negedge clk);
      m0_cyc_i = 1'b1; m0_stb_i = 1'b1; m0_addr_i = A0;
      m1_cyc_i = 1'b1; m1_stb_i = 1'b1; m1_addr_i = A2;
      #1 check_eq("tie_idle", WS'(mem_cyc_o), '0);
      for (int k = 0; k < 4; k++) begin
         @(negedge clk);
         m0_stb_i = 1'b1; mem_ack_i = 1'b1;
         #1;
         check_eq("burst_ack0", WS'(m0_ack_o), WS'(1));
         check_eq("burst_ack1", WS'(m1_ack_o), '0);
         @(negedge clk);
         m0_stb_i = 1'b0; mem_ack_i = 1'b1;
         #1;
         check_eq("burst_nostb_ack", WS'(m0_ack_o), '0);
         check_eq("burst_addr", WS'(mem_addr_o), WS'(A0));
      end
      @(negedge clk);
      m0_cyc_i = 1'b0; mem_ack_i = 1'b0;
      #1 check_eq("burst_drop", WS'(mem_cyc_o), '0);
      @(negedge clk); #1;
      check_eq("starve_gap", WS'(mem_cyc_o), '0);
      @(negedge clk); #1;
      check_eq("starve_g1_cyc",  WS'(mem_cyc_o), WS'(1));
      check_eq("starve_g1_addr", WS'(mem_addr_o), WS'(A2));

      // reset mid-GRANT1 with ack in the same cycle
      mem_ack_i = 1'b1;
      #1 check_eq("pre_rst_ack1", WS'(m1_ack_o), WS'(1));
      rst = 1'b1;
      #1;
      check_eq("rst_mid_cyc",  WS'(mem_cyc_o), '0);
      check_eq("rst_mid_ack1", WS'(m1_ack_o), '0);
      check_eq("rst_mid_addr", WS'(mem_addr_o), '0);
      m0_cyc_i = 1'b1; m0_stb_i = 1'b1;
      @(negedge clk);
      rst = 1'b0; mem_ack_i = 1'b0;
      #1 check_eq("rel2_idle", WS'(mem_cyc_o), '0);

      // m0 read never acked: err on the 8th stalled cycle
      for (int i = 1; i < 8; i++) begin
         @(negedge clk); #1;
         if (i == 1) check_eq("rel2_g0_addr", WS'(mem_addr_o), WS'(A0));
         check_eq("to_stall_cyc", WS'(mem_cyc_o), WS'(1));
         check_eq("to_stall_err", WS'(m0_err_o), '0);
      end
      @(negedge clk); #1;
      check_eq("to_err0",  WS'(m0_err_o), WS'(1));
      check_eq("to_err1",  WS'(m1_err_o), '0);
      check_eq("to_cyc",   WS'(mem_cyc_o), '0);
      check_eq("to_stb",   WS'(mem_stb_o), '0);
      @(negedge clk); #1;
      check_eq("to_idle_cyc", WS'(mem_cyc_o), '0);
      check_eq("to_idle_err", WS'(m0_err_o), '0);

      // after timeout the tie goes to m1; ack on the 8th stall beats the timeout
      for (int i = 1; i < 8; i++) begin
         @(negedge clk); #1;
         if (i == 1) begin
            check_eq("post_to_addr", WS'(mem_addr_o), WS'(A2));
            check_eq("post_to_cyc",  WS'(mem_cyc_o), WS'(1));
         end
         check_eq("race_stall_err", WS'(m1_err_o), '0);
      end
      @(negedge clk);
      mem_ack_i = 1'b1;
      #1;
      check_eq("race_ack", WS'(m1_ack_o), WS'(1));
      check_eq("race_err", WS'(m1_err_o), '0);
      check_eq("race_cyc", WS'(mem_cyc_o), WS'(1));
      @(negedge clk);
      mem_ack_i = 1'b0;
      m0_cyc_i = 1'b0; m0_stb_i = 1'b0; m1_cyc_i = 1'b0; m1_stb_i = 1'b0;
      #1 check_eq("race_after_err", WS'(m1_err_o), '0);
      @(negedge clk); #1;
      check_eq("final_idle", WS'(mem_cyc_o), '0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
